// File: rtl/mem_access_unit.sv
// Load/store unit: maps RV32 byte/half/word loads and stores onto a word-wide data memory.
// Latency accept->done: fault/illegal 1 cycle, load and SW 2 cycles, SB/SH 3 cycles (read-modify-write).
// Backpressure: stall holds the upstream pipeline from the accept cycle until the FSM is back in IDLE.
module mem_access_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        oob,
    output logic        dm_MemRead,
    output logic        dm_MemWrite,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_data_in,
    input  logic [31:0] dm_data_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Word index limit, sized to match addr[31:2].
    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state_q;
    state_t      state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [31:0] rmw_q;

    logic        accept;
    logic        f3_legal;
    logic        acc_mis;
    logic        acc_oob;
    logic        acc_fault;
    logic [31:0] load_ext;
    logic [31:0] merge_word;

    // Requests are only looked at while idle; either direction bit qualifies.
    assign accept = (state_q == S_IDLE) & req_valid & (req_read | req_write);

    // Upstream is held for the whole operation, including the accept cycle itself.
    assign stall = (state_q != S_IDLE) | accept;

    // Memory always sees the word-aligned version of the latched address.
    assign dm_addr = {addr_q[31:2], 2'b00};

    // Decode the incoming request: legality, alignment and range (misaligned wins over oob).
    always_comb begin
        f3_legal = 1'b0;
        acc_mis  = 1'b0;
        case (funct3)
            F3_B, F3_BU: f3_legal = 1'b1;
            F3_H, F3_HU: begin
                f3_legal = 1'b1;
                acc_mis  = addr[0];
            end
            F3_W: begin
                f3_legal = 1'b1;
                acc_mis  = (addr[1:0] != 2'b00);
            end
            default: f3_legal = 1'b0;
        endcase
        acc_oob   = f3_legal & ~acc_mis & (addr[31:2] >= WORD_LIMIT);
        acc_fault = ~f3_legal | acc_mis | acc_oob;
    end

    // Extract and extend the addressed byte/half from the memory word for loads.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b   = dm_data_out[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = dm_data_out[{addr_q[1], 4'b0000} +: 16];
        load_ext = dm_data_out;
        case (funct3_q)
            F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
            F3_BU:   load_ext = {24'd0, lane_b};
            F3_HU:   load_ext = {16'd0, lane_h};
            default: load_ext = dm_data_out;
        endcase
    end

    // Splice the store byte/half into the word read during RMW_RD.
    always_comb begin
        merge_word = rmw_q;
        if (funct3_q[0]) begin
            if (addr_q[1]) merge_word[31:16] = wdata_q[15:0];
            else           merge_word[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0:    merge_word[7:0]   = wdata_q[7:0];
                2'd1:    merge_word[15:8]  = wdata_q[7:0];
                2'd2:    merge_word[23:16] = wdata_q[7:0];
                default: merge_word[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Next-state and memory strobes; strobes are pure functions of the current state.
    always_comb begin
        state_d     = state_q;
        dm_MemRead  = 1'b0;
        dm_MemWrite = 1'b0;
        dm_data_in  = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (accept && !acc_fault) begin
                    if (req_read)            state_d = S_LOAD;
                    else if (funct3 == F3_W) state_d = S_STORE;
                    else                     state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                dm_MemRead = 1'b1;
                state_d    = S_IDLE;
            end
            S_STORE: begin
                dm_MemWrite = 1'b1;
                dm_data_in  = wdata_q;
                state_d     = S_IDLE;
            end
            S_RMW_RD: begin
                dm_MemRead = 1'b1;
                state_d    = S_RMW_WR;
            end
            S_RMW_WR: begin
                dm_MemWrite = 1'b1;
                dm_data_in  = merge_word;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation, including a pending RMW write.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Capture the request on accept and the old memory word during RMW_RD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            rmw_q    <= 32'd0;
        end else begin
            if (accept) begin
                addr_q   <= addr;
                funct3_q <= funct3;
                // A read+write request behaves as a load, so its store data is dropped.
                wdata_q  <= req_read ? 32'd0 : wdata;
            end
            if (state_q == S_RMW_RD) rmw_q <= dm_data_out;
        end
    end

    // Completion pulse and result flags; all are zero outside the done cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done       <= 1'b0;
            rdata      <= 32'd0;
            misaligned <= 1'b0;
            oob        <= 1'b0;
        end else begin
            done       <= 1'b0;
            rdata      <= 32'd0;
            misaligned <= 1'b0;
            oob        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && acc_fault) begin
                        done       <= 1'b1;
                        misaligned <= acc_mis;
                        oob        <= acc_oob;
                    end
                end
                S_LOAD: begin
                    done  <= 1'b1;
                    rdata <= load_ext;
                end
                S_STORE, S_RMW_WR: done <= 1'b1;
                default: done <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        oob;
    logic        dm_MemRead;
    logic        dm_MemWrite;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_in;
    logic [31:0] dm_data_out;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        oob;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'd0;

    mem_access_unit #(.MEM_WORDS(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata),
        .misaligned(misaligned), .oob(oob),
        .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
        .dm_addr(dm_addr), .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, write on rising edge; preload port for the bench.
    assign dm_data_out = mem[dm_addr[7:2]];
    always @(posedge clk) begin
        if (pl_en)            mem[pl_idx] <= pl_val;
        else if (dm_MemWrite) mem[dm_addr[7:2]] <= dm_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                chk("oob", {31'd0, oob}, {31'd0, e.oob});
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = 6'(idx);
        pl_val = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int lat, input logic exp_wr, input logic [31:0] exp_wdat,
                           input logic [31:0] exp_rdata, input logic exp_mis, input logic exp_oob);
        int          cyc;
        logic        wseen;
        logic [31:0] wdat;
        logic        got_done;
        exp_t        e;
        @(negedge clk);
        req_valid = 1'b1;
        req_read  = rd;
        req_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        e.rdata = exp_rdata;
        e.mis   = exp_mis;
        e.oob   = exp_oob;
        sb.push_back(e);
        #1 chk({tag, "_stall_accept"}, {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        cyc      = 1;
        wseen    = 1'b0;
        wdat     = 32'd0;
        got_done = 1'b0;
        for (int k = 0; k < 10 && !got_done; k++) begin
            @(negedge clk);
            if (dm_MemWrite === 1'b1) begin
                wseen = 1'b1;
                wdat  = dm_data_in;
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                chk({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
                @(posedge clk);
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, "_write_seen"}, {31'd0, wseen}, {31'd0, exp_wr});
        if (exp_wr) chk({tag, "_write_data"}, wdat, exp_wdat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        chk("rst_oob", {31'd0, oob}, 32'd0);
        chk("rst_memread", {31'd0, dm_MemRead}, 32'd0);
        chk("rst_memwrite", {31'd0, dm_MemWrite}, 32'd0);
        rst = 1'b1;

        // Word load
        preload(2, 32'd25);
        run_req("lw8", 1, 0, 3'b010, 32'h8, 32'h0, 2, 0, 32'h0, 32'd25, 0, 0);

        // Sub-word loads and extension
        preload(1, 32'h0000_80FF);
        run_req("lb4",   1, 0, 3'b000, 32'h4, 32'h0, 2, 0, 32'h0, 32'hFFFF_FFFF, 0, 0);
        run_req("lb5",   1, 0, 3'b000, 32'h5, 32'h0, 2, 0, 32'h0, 32'hFFFF_FF80, 0, 0);
        run_req("lbu5",  1, 0, 3'b100, 32'h5, 32'h0, 2, 0, 32'h0, 32'h0000_0080, 0, 0);
        run_req("lh4",   1, 0, 3'b001, 32'h4, 32'h0, 2, 0, 32'h0, 32'hFFFF_80FF, 0, 0);
        run_req("lhu4",  1, 0, 3'b101, 32'h4, 32'h0, 2, 0, 32'h0, 32'h0000_80FF, 0, 0);
        run_req("rw_as_load", 1, 1, 3'b010, 32'h4, 32'h1234_5678, 2, 0, 32'h0, 32'h0000_80FF, 0, 0);
        preload(3, 32'h8001_7F02);
        run_req("lhE",   1, 0, 3'b001, 32'hE, 32'h0, 2, 0, 32'h0, 32'hFFFF_8001, 0, 0);
        run_req("lhuE",  1, 0, 3'b101, 32'hE, 32'h0, 2, 0, 32'h0, 32'h0000_8001, 0, 0);
        run_req("lbC",   1, 0, 3'b000, 32'hC, 32'h0, 2, 0, 32'h0, 32'h0000_0002, 0, 0);
        run_req("lbD",   1, 0, 3'b000, 32'hD, 32'h0, 2, 0, 32'h0, 32'h0000_007F, 0, 0);
        run_req("lbuF",  1, 0, 3'b100, 32'hF, 32'h0, 2, 0, 32'h0, 32'h0000_0080, 0, 0);

        // Stores: byte/half read-modify-write, word direct
        preload(1, 32'h1122_3344);
        run_req("sb6",   0, 1, 3'b000, 32'h6, 32'hFFFF_FFAB, 3, 1, 32'h11AB_3344, 32'h0, 0, 0);
        run_req("lw4a",  1, 0, 3'b010, 32'h4, 32'h0, 2, 0, 32'h0, 32'h11AB_3344, 0, 0);
        run_req("sh6",   0, 1, 3'b001, 32'h6, 32'h9999_CDEF, 3, 1, 32'hCDEF_3344, 32'h0, 0, 0);
        run_req("sb4",   0, 1, 3'b000, 32'h4, 32'h0000_0055, 3, 1, 32'hCDEF_3355, 32'h0, 0, 0);
        run_req("sw8",   0, 1, 3'b010, 32'h8, 32'hDEAD_BEEF, 2, 1, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_req("lw8b",  1, 0, 3'b010, 32'h8, 32'h0, 2, 0, 32'h0, 32'hDEAD_BEEF, 0, 0);

        // Faults and range boundary
        run_req("sh3_mis",   0, 1, 3'b001, 32'h3,   32'hFFFF, 1, 0, 32'h0, 32'h0, 1, 0);
        run_req("lw100_oob", 1, 0, 3'b010, 32'h100, 32'h0,    1, 0, 32'h0, 32'h0, 0, 1);
        run_req("lw101_pri", 1, 0, 3'b010, 32'h101, 32'h0,    1, 0, 32'h0, 32'h0, 1, 0);
        run_req("illegal",   1, 0, 3'b011, 32'h4,   32'h0,    1, 0, 32'h0, 32'h0, 0, 0);
        preload(63, 32'hA5A5_A5A5);
        run_req("lwFC_last", 1, 0, 3'b010, 32'hFC,  32'h0,    2, 0, 32'h0, 32'hA5A5_A5A5, 0, 0);

        // Reset during RMW_RD aborts the store
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
        funct3 = 3'b000; addr = 32'h4; wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_rmw_rd", {31'd0, dm_MemRead}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_write", {31'd0, dm_MemWrite}, 32'd0);
            chk("abort_no_done", {31'd0, done}, 32'd0);
            chk("abort_idle", {31'd0, stall}, 32'd0);
        end
        run_req("lw_after_abort", 1, 0, 3'b010, 32'h4, 32'h0, 2, 0, 32'h0, 32'hCDEF_3355, 0, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
